id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised successor decode stage for the in-order RV32I pipeline, sitting between the IF and EX stages.
- Integrates control decode, immediate generation, and an XLEN x NREGS register file with optional write-back bypass.
- Adds a registered ID/EX output with valid/ready handshake, load-use hazard bubble insertion, and flush.
- Fixed latency is 1 cycle from an accepted instruction to a valid output.

Parameters:
- XLEN, 32, datapath width of register data and immediates (>=32).
- NREGS, 32, number of architectural registers (power of 2, 2..32); RA = log2(NREGS).
- BYPASS, 1, 1 = same-cycle write-back data forwarded to rs reads; 0 = no forwarding.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- if_valid  in  1  instruction on `instruction` is valid.
- if_ready  out  1  stage accepts the instruction this cycle.
- instruction  in  32  RV32I instruction word.
- flush  in  1  kill the held output and the incoming instruction.
- wb_en  in  1  write-back enable.
- wb_rd  in  RA  write-back destination register.
- wb_data  in  XLEN  write-back data.
- ex_ready  in  1  EX stage accepts the ID output.
- id_valid  out  1  ID/EX register holds a valid instruction.
- rs1_data, rs2_data  out  XLEN  operand values.
- imm_out  out  XLEN  sign-extended immediate.
- rd_out  out  RA  destination register.
- opcode_out  out  7  opcode.
- fn3_out  out  3  funct3.
- fn7_5  out  1  instruction bit 30.
- reg_write, mem_read, mem_write, alu_src, branch  out  1  control signals.
- memtoreg  out  2  00 = ALU result, 01 = memory data, 10 = PC+4.
- aluop  out  3  ALU operation class.
- illegal  out  1  unsupported opcode.

Behaviour:
- Reset (asynchronous, reset=0):
  - All outputs are 0, including id_valid=0.
  - All registers are cleared to 0.
  - if_ready=0 while reset is asserted.
- Register index fields: rs1=instr[15+RA-1:15], rs2=instr[20+RA-1:20], rd=instr[7+RA-1:7]. Index bits above RA are ignored.
- Register file:
  - x0 reads 0 and writes to it are dropped.
  - Write occurs at the clock edge when wb_en=1 and wb_rd!=0.
  - Reads are combinational.
  - BYPASS=1: if wb_en=1, wb_rd==rs and rs!=0, the read returns wb_data.
  - BYPASS=0: the read returns the old register value.
- Decode, by opcode (unlisted control signals are 0):
  - 0110011 (R-type): reg_write=1, aluop=010.
  - 0010011 (I-ALU): reg_write=1, alu_src=1, aluop=011.
  - 0000011 (load): reg_write=1, mem_read=1, alu_src=1, memtoreg=01, aluop=000.
  - 0100011 (store): mem_write=1, alu_src=1, aluop=000.
  - 1100011 (branch): branch=1, aluop=001.
  - 1101111 (JAL): reg_write=1, branch=1, memtoreg=10, aluop=101.
  - 0110111 (LUI): reg_write=1, alu_src=1, aluop=100.
  - Any other opcode: all control signals 0 and illegal=1. The instruction still flows as a valid no-op.
- Immediate generation, standard I/S/B/U/J formats, sign-extended from instr[31] to XLEN:
  - U-type: imm = instr[31:12] << 12, sign-extended.
  - R-type: imm = 0.
- Operand usage:
  - rs1 is used by all opcodes except LUI and JAL.
  - rs2 is used by R-type, store and branch.
- Hazard: hazard = id_valid & mem_read(out) & rd_out!=0 & (rd_out matches a used rs1 or rs2 of `instruction`) & if_valid.
- Handshake: adv = !id_valid | ex_ready; if_ready = adv & !hazard & !flush.
- Clock-edge update, in priority order:
  - flush=1: id_valid<=0 and the input is not accepted.
  - Else if if_valid & if_ready: the output register loads the decoded fields and operands; id_valid<=1.
  - Else if adv: id_valid<=0 (this is a bubble when the cause is a hazard).
  - Else: hold all outputs stable. Payload must not change while id_valid=1 and ex_ready=0.
- A hazard costs exactly one bubble cycle. The next cycle the held instruction is accepted, provided the upstream keeps it stable.
- Simultaneous write-back and decode of the same register: with BYPASS=1 the ID output captures wb_data.
- Reset mid-stall: returns to the reset state immediately; the held instruction is lost.

Test Plan:
1. After reset, wb_en with wb_rd=5 and wb_data=0x1234, then decode ADD x3,x5,x0 -> next cycle id_valid=1, rs1_data=0x1234, rs2_data=0, reg_write=1, aluop=010.
2. BYPASS=1: wb x7=0xAA in the same cycle as decoding ADDI x1,x7,-4 -> rs1_data=0xAA, imm_out=0xFFFFFFFC, alu_src=1. Repeat with BYPASS=0 -> rs1_data=0.
3. LW x4,0(x2) followed by ADD x6,x4,x1 with ex_ready=1 -> if_ready=0 for 1 cycle, id_valid=0 bubble, then ADD is issued with rd_out=6.
4. ex_ready=0 for 3 cycles with id_valid=1 -> all outputs held and if_ready=0; ex_ready=1 -> the next instruction is accepted.
5. flush with if_valid=1 -> id_valid=0 on the next cycle and the instruction is dropped. Write to x0 with 0xFFFF -> x0 still reads 0.
6. Opcode 0x7F -> illegal=1 with all control signals 0. JAL with offset -8 -> imm_out=0xFFFFFFF8, memtoreg=10. Reset asserted mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode stage with register file, immediate generation,
// load-use bubble insertion, flush, and a registered ID/EX output behind a
// valid/ready handshake. Accepted instructions appear on the output one cycle later.
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-low reset
//   if_valid/if_ready - upstream handshake; instruction is the 32-bit word
//   flush             - drops the held output and the incoming instruction
//   wb_en/wb_rd/wb_data - register file write-back
//   ex_ready/id_valid - downstream handshake
//   rs1_data..illegal - registered decoded payload
module id_stage_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [31:0]                instruction,
  input  logic                       flush,
  input  logic                       wb_en,
  input  logic [$clog2(NREGS)-1:0]   wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       ex_ready,
  output logic                       id_valid,
  output logic [XLEN-1:0]            rs1_data,
  output logic [XLEN-1:0]            rs2_data,
  output logic [XLEN-1:0]            imm_out,
  output logic [$clog2(NREGS)-1:0]   rd_out,
  output logic [6:0]                 opcode_out,
  output logic [2:0]                 fn3_out,
  output logic                       fn7_5,
  output logic                       reg_write,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       alu_src,
  output logic                       branch,
  output logic [1:0]                 memtoreg,
  output logic [2:0]                 aluop,
  output logic                       illegal
);

  localparam int unsigned RA = $clog2(NREGS);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic [XLEN-1:0] r_regs [NREGS];

  logic [6:0]          w_opc;
  logic [RA-1:0]       w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0]     w_rs1_data, w_rs2_data, w_imm;
  logic signed [31:0]  w_imm32;
  logic [31:0]         w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic                w_reg_write, w_mem_read, w_mem_write, w_alu_src, w_branch;
  logic [1:0]          w_memtoreg;
  logic [2:0]          w_aluop;
  logic                w_illegal, w_use_rs1, w_use_rs2;
  logic                w_hazard, w_adv, w_if_ready;

  assign w_opc = instruction[6:0];
  assign w_rs1 = instruction[15 +: RA];
  assign w_rs2 = instruction[20 +: RA];
  assign w_rd  = instruction[7 +: RA];

  assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
  assign w_imm_u = {instruction[31:12], 12'b0};
  assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
  // Signed cast widens the 32-bit immediate to XLEN with sign extension
  assign w_imm   = XLEN'(w_imm32);

  // Control decode, immediate select and operand usage
  always_comb begin
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_alu_src   = 1'b0;
    w_branch    = 1'b0;
    w_memtoreg  = 2'b00;
    w_aluop     = 3'b000;
    w_illegal   = 1'b0;
    w_imm32     = '0;
    w_use_rs1   = 1'b1;
    w_use_rs2   = 1'b0;
    unique case (w_opc)
      OP_R: begin
        w_reg_write = 1'b1; w_aluop = 3'b010; w_use_rs2 = 1'b1;
      end
      OP_I: begin
        w_reg_write = 1'b1; w_alu_src = 1'b1; w_aluop = 3'b011; w_imm32 = w_imm_i;
      end
      OP_LOAD: begin
        w_reg_write = 1'b1; w_mem_read = 1'b1; w_alu_src = 1'b1;
        w_memtoreg = 2'b01; w_imm32 = w_imm_i;
      end
      OP_STORE: begin
        w_mem_write = 1'b1; w_alu_src = 1'b1; w_use_rs2 = 1'b1; w_imm32 = w_imm_s;
      end
      OP_BR: begin
        w_branch = 1'b1; w_aluop = 3'b001; w_use_rs2 = 1'b1; w_imm32 = w_imm_b;
      end
      OP_JAL: begin
        w_reg_write = 1'b1; w_branch = 1'b1; w_memtoreg = 2'b10; w_aluop = 3'b101;
        w_use_rs1 = 1'b0; w_imm32 = w_imm_j;
      end
      OP_LUI: begin
        w_reg_write = 1'b1; w_alu_src = 1'b1; w_aluop = 3'b100;
        w_use_rs1 = 1'b0; w_imm32 = w_imm_u;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Combinational reads; x0 is hard zero, same-cycle write-back optionally forwarded
  always_comb begin
    w_rs1_data = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    w_rs2_data = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
    if ((BYPASS != 0) && wb_en && (wb_rd == w_rs1) && (w_rs1 != '0)) w_rs1_data = wb_data;
    if ((BYPASS != 0) && wb_en && (wb_rd == w_rs2) && (w_rs2 != '0)) w_rs2_data = wb_data;
  end

  // Load-use: the held load's destination feeds an operand of the incoming instruction
  assign w_hazard = id_valid & mem_read & (rd_out != '0) & if_valid &
                    ((w_use_rs1 & (rd_out == w_rs1)) | (w_use_rs2 & (rd_out == w_rs2)));
  assign w_adv      = ~id_valid | ex_ready;
  assign w_if_ready = reset & w_adv & ~w_hazard & ~flush;
  assign if_ready   = w_if_ready;

  // Register file write port; x0 writes dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // ID/EX output register: flush > accept > drain > hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid   <= 1'b0;
      rs1_data   <= '0;
      rs2_data   <= '0;
      imm_out    <= '0;
      rd_out     <= '0;
      opcode_out <= '0;
      fn3_out    <= '0;
      fn7_5      <= 1'b0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      alu_src    <= 1'b0;
      branch     <= 1'b0;
      memtoreg   <= '0;
      aluop      <= '0;
      illegal    <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (if_valid && w_if_ready) begin
      id_valid   <= 1'b1;
      rs1_data   <= w_rs1_data;
      rs2_data   <= w_rs2_data;
      imm_out    <= w_imm;
      rd_out     <= w_rd;
      opcode_out <= w_opc;
      fn3_out    <= instruction[14:12];
      fn7_5      <= instruction[30];
      reg_write  <= w_reg_write;
      mem_read   <= w_mem_read;
      mem_write  <= w_mem_write;
      alu_src    <= w_alu_src;
      branch     <= w_branch;
      memtoreg   <= w_memtoreg;
      aluop      <= w_aluop;
      illegal    <= w_illegal;
    end else if (w_adv) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, if_valid, flush, wb_en, ex_ready;
  logic [31:0] instruction, wb_data;
  logic [4:0]  wb_rd;

  logic        if_ready, id_valid, fn7_5, reg_write, mem_read, mem_write, alu_src, branch, illegal;
  logic [31:0] rs1_data, rs2_data, imm_out;
  logic [4:0]  rd_out;
  logic [6:0]  opcode_out;
  logic [2:0]  fn3_out, aluop;
  logic [1:0]  memtoreg;

  logic        b_if_ready, b_id_valid, b_fn7_5, b_reg_write, b_mem_read, b_mem_write;
  logic        b_alu_src, b_branch, b_illegal;
  logic [31:0] b_rs1_data, b_rs2_data, b_imm_out;
  logic [4:0]  b_rd_out;
  logic [6:0]  b_opcode_out;
  logic [2:0]  b_fn3_out, b_aluop;
  logic [1:0]  b_memtoreg;

  id_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .instruction(instruction), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .id_valid(id_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_out(imm_out), .rd_out(rd_out),
    .opcode_out(opcode_out), .fn3_out(fn3_out), .fn7_5(fn7_5),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .branch(branch), .memtoreg(memtoreg), .aluop(aluop),
    .illegal(illegal)
  );

  id_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(b_if_ready),
    .instruction(instruction), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_ready(ex_ready), .id_valid(b_id_valid),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .imm_out(b_imm_out), .rd_out(b_rd_out),
    .opcode_out(b_opcode_out), .fn3_out(b_fn3_out), .fn7_5(b_fn7_5),
    .reg_write(b_reg_write), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .alu_src(b_alu_src), .branch(b_branch), .memtoreg(b_memtoreg), .aluop(b_aluop),
    .illegal(b_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs1, rs2, imm;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  fn3;
    logic        f7;
    logic [4:0]  flags;  // reg_write, mem_read, mem_write, alu_src, branch
    logic [1:0]  m2r;
    logic [2:0]  aop;
    logic        ill;
  } out_t;

  out_t act;
  assign act = {rs1_data, rs2_data, imm_out, rd_out, opcode_out, fn3_out, fn7_5,
                reg_write, mem_read, mem_write, alu_src, branch, memtoreg, aluop, illegal};

  out_t q[$];
  int   n_err = 0;
  int   n_chk = 0;

  function automatic out_t mk(input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic [6:0] opc, input logic [2:0] fn3, input logic f7,
                              input logic [4:0] flags, input logic [1:0] m2r,
                              input logic [2:0] aop, input logic ill);
    out_t e;
    e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd; e.opc = opc; e.fn3 = fn3;
    e.f7 = f7; e.flags = flags; e.m2r = m2r; e.aop = aop; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: every transfer to EX is matched against the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      if (reset && id_valid && ex_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_output: got=%h exp=none", act);
        end else begin
          chk("id_out", act, q.pop_front());
        end
      end
    end
  end

  // Present an instruction until accepted; expectation is queued at acceptance
  task automatic send(input logic [31:0] ins, input out_t e);
    int n;
    if_valid = 1'b1; instruction = ins; n = 0;
    @(negedge clk);
    while (!if_ready && n < 20) begin @(negedge clk); n++; end
    if (!if_ready) begin
      n_chk++; n_err++;
      $display("FAIL send_timeout: got if_ready=0 exp=1 for %h", ins);
    end else begin
      q.push_back(e);
    end
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = rd; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  localparam logic [31:0] I_ADD3  = 32'h000281B3;  // add x3,x5,x0
  localparam logic [31:0] I_ADDI  = 32'hFFC38093;  // addi x1,x7,-4
  localparam logic [31:0] I_LW    = 32'h00012203;  // lw x4,0(x2)
  localparam logic [31:0] I_ADD6  = 32'h00120333;  // add x6,x4,x1
  localparam logic [31:0] I_SW    = 32'h0051A423;  // sw x5,8(x3)
  localparam logic [31:0] I_LUI   = 32'h123454B7;  // lui x9,0x12345
  localparam logic [31:0] I_ADD10 = 32'h00000533;  // add x10,x0,x0
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_JAL   = 32'hFF9FF0EF;  // jal x1,-8

  out_t e_sw;

  initial begin
    reset = 1'b0; if_valid = 1'b1; instruction = I_ADD3; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
    e_sw = mk(32'h0, 32'h1234, 32'h8, 5'd8, 7'h23, 3'd2, 1'b0, 5'b00110, 2'b00, 3'b000, 1'b0);

    @(negedge clk);
    chk("rst_payload", act, '0);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_if_ready", if_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; if_valid = 1'b0;

    // Write-back then decode
    wb(5'd5, 32'h1234);
    wb(5'd1, 32'h55);
    send(I_ADD3, mk(32'h1234, 32'h0, 32'h0, 5'd3, 7'h33, 3'd0, 1'b0, 5'b10000, 2'b00, 3'b010, 1'b0));

    // Same-cycle write-back and read of x7
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
    send(I_ADDI, mk(32'hAA, 32'h0, 32'hFFFFFFFC, 5'd1, 7'h13, 3'd0, 1'b1, 5'b10010, 2'b00, 3'b011, 1'b0));
    wb_en = 1'b0;
    @(negedge clk);
    chk("nobypass_rs1", b_rs1_data, 32'h0);
    chk("nobypass_imm", b_imm_out, 32'hFFFFFFFC);
    @(posedge clk); #1;

    // Load-use: one bubble, then the dependent ADD issues
    send(I_LW, mk(32'h0, 32'h0, 32'h0, 5'd4, 7'h03, 3'd2, 1'b0, 5'b11010, 2'b01, 3'b000, 1'b0));
    if_valid = 1'b1; instruction = I_ADD6;
    @(negedge clk);
    chk("hazard_if_ready", if_ready, 1'b0);
    @(negedge clk);
    chk("bubble_valid", id_valid, 1'b0);
    chk("post_bubble_ready", if_ready, 1'b1);
    q.push_back(mk(32'h0, 32'h55, 32'h0, 5'd6, 7'h33, 3'd0, 1'b0, 5'b10000, 2'b00, 3'b010, 1'b0));
    @(posedge clk); #1;
    if_valid = 1'b0;

    // Downstream stall for three cycles: output held, nothing accepted
    send(I_SW, e_sw);
    ex_ready = 1'b0; if_valid = 1'b1; instruction = I_LUI;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_if_ready", if_ready, 1'b0);
      chk("stall_valid", id_valid, 1'b1);
      chk("stall_hold", act, e_sw);
    end
    @(posedge clk); #1;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("resume_if_ready", if_ready, 1'b1);
    q.push_back(mk(32'h0, 32'h0, 32'h12345000, 5'd9, 7'h37, 3'd5, 1'b0, 5'b10010, 2'b00, 3'b100, 1'b0));
    @(posedge clk); #1;

    // Flush drops the incoming instruction
    instruction = I_ADDI; flush = 1'b1;
    @(negedge clk);
    chk("flush_if_ready", if_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", id_valid, 1'b0);
    @(posedge clk); #1;

    // x0 write is dropped and never forwarded
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    send(I_ADD10, mk(32'h0, 32'h0, 32'h0, 5'd10, 7'h33, 3'd0, 1'b0, 5'b10000, 2'b00, 3'b010, 1'b0));
    wb_en = 1'b0;
    send(I_ILL, mk(32'h0, 32'h0, 32'h0, 5'd0, 7'h7F, 3'd0, 1'b0, 5'b00000, 2'b00, 3'b000, 1'b1));
    send(I_JAL, mk(32'h0, 32'h0, 32'hFFFFFFF8, 5'd1, 7'h6F, 3'd7, 1'b1, 5'b10001, 2'b10, 3'b101, 1'b0));
    @(negedge clk);
    @(posedge clk); #1;

    // Reset while a load is stalled at the output
    ex_ready = 1'b0; if_valid = 1'b1; instruction = I_LW;
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", id_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midstall_rst_payload", act, '0);
    chk("midstall_rst_valid", id_valid, 1'b0);
    chk("midstall_rst_if_ready", if_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; ex_ready = 1'b1;

    // Register file cleared by reset: x5 reads 0 again
    send(I_ADD3, mk(32'h0, 32'h0, 32'h0, 5'd3, 7'h33, 3'd0, 1'b0, 5'b10000, 2'b00, 3'b010, 1'b0));
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
